// File: rtl/read_bram_if.sv
// read_bram_if: bundles the configuration inputs, the block-RAM read port
// and the downstream stream port of read_bram.
// master = the read_bram side, slave = the memory/consumer side.
interface read_bram_if #(
   parameter int DATA_WIDTH             = 8,
   parameter int LOG_MAX_ITERS          = 16,
   parameter int LOG_MAX_READS_PER_ITER = 16,
   parameter int LOG_MAX_ADDRESS        = 16
);
   logic                              configure;
   logic [LOG_MAX_ITERS-1:0]          num_iters;
   logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter;
   logic [LOG_MAX_ADDRESS-1:0]        base_address;
   logic [LOG_MAX_ADDRESS-1:0]        address_out;
   logic                              read_out;
   logic [DATA_WIDTH-1:0]             data_in;
   logic [DATA_WIDTH-1:0]             data_out;
   logic                              valid_out;
   logic                              avail_in;
   logic                              done_out;

   modport master (
      input  configure, num_iters, num_reads_per_iter, base_address,
      input  data_in, avail_in,
      output address_out, read_out, data_out, valid_out, done_out
   );

   modport slave (
      output configure, num_iters, num_reads_per_iter, base_address,
      output data_in, avail_in,
      input  address_out, read_out, data_out, valid_out, done_out
   );
endinterface

// File: rtl/read_bram.sv
// read_bram: streams an address window out of a block RAM once per
// iteration into a 4-entry FIFO and hands words to the downstream stage
// whenever it signals avail_in.
// Optional feature macro: READ_BRAM_DEBUG_EN (cycle counter + read/output trace).
module read_bram #(
   parameter int DATA_WIDTH             = 8,
   parameter int LOG_MAX_ITERS          = 16,
   parameter int LOG_MAX_READS_PER_ITER = 16,
   parameter int LOG_MAX_ADDRESS        = 16
) (
   input logic        clk,
   input logic        rst,
   read_bram_if.master bus
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [LOG_MAX_ITERS-1:0]          ITER_ONE = 1;
   localparam logic [LOG_MAX_READS_PER_ITER-1:0] RD_ONE   = 1;
   localparam logic [LOG_MAX_ADDRESS-1:0]        ADDR_ONE = 1;

   state_t                            state, state_next;
   logic [LOG_MAX_ITERS-1:0]          iter_cnt;
   logic [LOG_MAX_READS_PER_ITER-1:0] rd_cnt;
   logic [LOG_MAX_READS_PER_ITER-1:0] reads_q;
   logic [LOG_MAX_ADDRESS-1:0]        addr;
   logic [LOG_MAX_ADDRESS-1:0]        base_q;

   logic [DATA_WIDTH-1:0] buf_mem [4];
   logic [1:0]            wr_ptr, rd_ptr;
   logic [2:0]            occ;
   logic                  inflight;

   logic counts_ok, issue, last_issue, push, pop, done;

   // A job only starts when both counts are non-zero.
   assign counts_ok  = (bus.num_iters != '0) && (bus.num_reads_per_iter != '0);
   // Slots already claimed = buffered words plus the word coming back next edge.
   assign issue      = (state == READ) && ((occ + {2'b00, inflight}) < 3'd4);
   assign last_issue = issue && (rd_cnt == RD_ONE) && (iter_cnt == ITER_ONE);
   assign push       = inflight;
   assign pop        = (occ != 3'd0) && bus.avail_in;
   // A configure in the same cycle aborts the job, so it gets no done pulse.
   assign done       = (state == DRAIN) && (occ == 3'd0) && !inflight && !bus.configure;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic; configure overrides everything, including an abort.
   always_comb begin
      state_next = state;
      if (bus.configure) begin
         state_next = counts_ok ? READ : IDLE;
      end else begin
         case (state)
            READ:    if (last_issue) state_next = DRAIN;
            DRAIN:   if (done)       state_next = IDLE;
            default: state_next = state;
         endcase
      end
   end

   // Outputs: memory request, FIFO head and completion pulse.
   always_comb begin
      bus.read_out    = issue;
      bus.address_out = addr;
      bus.valid_out   = pop;
      bus.data_out    = (occ != 3'd0) ? buf_mem[rd_ptr] : '0;
      bus.done_out    = done;
   end

   // Iteration/read counters and address generator; reload the window on
   // the last read of every iteration except the final one.
   always_ff @(posedge clk) begin
      if (rst) begin
         iter_cnt <= '0;
         rd_cnt   <= '0;
         reads_q  <= '0;
         addr     <= '0;
         base_q   <= '0;
      end else if (bus.configure) begin
         iter_cnt <= bus.num_iters;
         rd_cnt   <= bus.num_reads_per_iter;
         reads_q  <= bus.num_reads_per_iter;
         addr     <= bus.base_address;
         base_q   <= bus.base_address;
      end else if (issue) begin
         if ((rd_cnt == RD_ONE) && (iter_cnt != ITER_ONE)) begin
            iter_cnt <= iter_cnt - ITER_ONE;
            rd_cnt   <= reads_q;
            addr     <= base_q;
         end else begin
            rd_cnt <= rd_cnt - RD_ONE;
            addr   <= addr + ADDR_ONE;
         end
      end
   end

   // FIFO control; configure flushes it and drops the in-flight word.
   always_ff @(posedge clk) begin
      if (rst || bus.configure) begin
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
      end else begin
         inflight <= issue;
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   occ <= occ + 3'd1;
            2'b01:   occ <= occ - 3'd1;
            default: occ <= occ;
         endcase
      end
   end

   // FIFO storage; returning memory data lands the cycle after read_out.
   always_ff @(posedge clk) begin
      if (push) buf_mem[wr_ptr] <= bus.data_in;
   end

`ifdef READ_BRAM_DEBUG_EN
   logic [15:0] dbg_cycle;

   // Free-running cycle counter with a trace of reads and delivered words.
   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_cycle <= '0;
      end else begin
         dbg_cycle <= dbg_cycle + 16'd1;
         if (issue) $display("READ: cycle %0d, addr %0h", dbg_cycle, addr);
         if (pop)   $display("READ: cycle %0d, data_out %0h", dbg_cycle, buf_mem[rd_ptr]);
      end
   end
`endif
endmodule

// File: tb/tb_read_bram.sv
// tb_read_bram: table-driven, hand-sequenced and randomized checks of read_bram
// against a window/iteration model of the expected read and output streams.
module tb_read_bram;
   localparam int DW = 8;
   localparam int LI = 16;
   localparam int LR = 16;
   localparam int LA = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   read_bram_if #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI),
                  .LOG_MAX_READS_PER_ITER(LR), .LOG_MAX_ADDRESS(LA)) bus ();

   read_bram #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI),
               .LOG_MAX_READS_PER_ITER(LR), .LOG_MAX_ADDRESS(LA)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [15:0] base;
      int          reads;
      int          iters;
      int          exp_first_rd;
      int          exp_first_vo;
      int          exp_done;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;
   int issued, delivered, bound_viol;
   int          rd_cyc[$];
   logic [15:0] rd_addr[$];
   int          vo_cyc[$];
   logic [7:0]  vo_data[$];
   int          done_cyc[$];
   logic [15:0] exp_addr[$];
   logic        pend_rd;
   logic [15:0] pend_addr;

   // Memory contents: distinct for the windows used below.
   function automatic logic [7:0] mem(input logic [15:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample outputs at the falling edge, respond as the memory.
   task automatic step();
      @(negedge clk);
      if (bus.read_out) begin
         rd_cyc.push_back(cyc);
         rd_addr.push_back(bus.address_out);
         issued++;
      end
      if (issued - delivered > 4) bound_viol++;
      if (bus.valid_out) begin
         vo_cyc.push_back(cyc);
         vo_data.push_back(bus.data_out);
         delivered++;
         if (!bus.avail_in) bound_viol++;
      end
      if (bus.done_out) done_cyc.push_back(cyc);
      pend_rd   = bus.read_out;
      pend_addr = bus.address_out;
      @(posedge clk);
      #1;
      bus.data_in = pend_rd ? mem(pend_addr) : 8'h00;
      cyc++;
   endtask

   task automatic clear_log();
      rd_cyc.delete(); rd_addr.delete(); vo_cyc.delete(); vo_data.delete();
      done_cyc.delete();
      issued = 0; delivered = 0; bound_viol = 0; cyc = 0;
   endtask

   // Expected address stream: the window re-read once per iteration.
   task automatic build_model(input logic [15:0] base, input int reads, input int iters);
      exp_addr.delete();
      for (int it = 0; it < iters; it++)
         for (int k = 0; k < reads; k++)
            exp_addr.push_back(base + 16'(k));
   endtask

   function automatic logic avail_for(input int mode, input int c);
      if (mode == 1) return ($urandom_range(0, 9) < 7);
      if (mode == 2) return (c > 20);
      return 1'b1;
   endfunction

   task automatic start_job(input logic [15:0] base, input int reads, input int iters, input int mode);
      bus.configure          = 1'b1;
      bus.base_address       = base;
      bus.num_reads_per_iter = 16'(reads);
      bus.num_iters          = 16'(iters);
      bus.avail_in           = avail_for(mode, cyc);
      step();
      bus.configure = 1'b0;
   endtask

   task automatic run_job(input logic [15:0] base, input int reads, input int iters,
                          input int mode, input int budget);
      clear_log();
      start_job(base, reads, iters, mode);
      while (cyc < budget && !(done_cyc.size() > 0 && cyc > done_cyc[0] + 2)) begin
         bus.avail_in = avail_for(mode, cyc);
         step();
      end
      bus.avail_in = 1'b1;
   endtask

   task automatic check_job(input string name, input logic [15:0] base, input int reads, input int iters);
      int n;
      build_model(base, reads, iters);
      n = exp_addr.size();
      check({name, ".reads"}, rd_addr.size(), n);
      check({name, ".outs"},  vo_data.size(), n);
      for (int i = 0; i < n && i < rd_addr.size(); i++)
         check({name, ".addr"}, rd_addr[i], exp_addr[i]);
      for (int i = 0; i < n && i < vo_data.size(); i++)
         check({name, ".data"}, vo_data[i], mem(exp_addr[i]));
      check({name, ".done_cnt"}, done_cyc.size(), (n > 0) ? 1 : 0);
      if (n > 0 && done_cyc.size() > 0 && vo_cyc.size() > 0)
         check({name, ".done_after_last"}, done_cyc[0], vo_cyc[vo_cyc.size()-1] + 1);
      check({name, ".bound"}, bound_viol, 0);
   endtask

   vec_t vt[6];
   int cnt_a, cnt_b;

   initial begin
      vt[0] = '{16'h0010, 4, 1, 1, 3, 7};
      vt[1] = '{16'h0005, 3, 2, 1, 3, 9};
      vt[2] = '{16'hFFFE, 4, 1, 1, 3, 7};
      vt[3] = '{16'h0030, 1, 1, 1, 3, 4};
      vt[4] = '{16'h0000, 0, 3, -1, -1, -1};
      vt[5] = '{16'h0040, 5, 0, -1, -1, -1};

      rst = 1'b1;
      bus.configure = 1'b0; bus.num_iters = '0; bus.num_reads_per_iter = '0;
      bus.base_address = '0; bus.data_in = '0; bus.avail_in = 1'b1;
      clear_log();
      step();
      step();
      check("rst.address_out", bus.address_out, 0);
      check("rst.read_out",    bus.read_out,    0);
      check("rst.data_out",    bus.data_out,    0);
      check("rst.valid_out",   bus.valid_out,   0);
      check("rst.done_out",    bus.done_out,    0);
      rst = 1'b0;
      step();

      // Directed table with avail_in held high.
      for (int v = 0; v < 6; v++) begin
         run_job(vt[v].base, vt[v].reads, vt[v].iters, 0,
                 (vt[v].reads * vt[v].iters == 0) ? 15 : 200);
         check_job($sformatf("vec%0d", v), vt[v].base, vt[v].reads, vt[v].iters);
         check($sformatf("vec%0d.first_rd", v), (rd_cyc.size() > 0) ? rd_cyc[0] : -1, vt[v].exp_first_rd);
         check($sformatf("vec%0d.first_vo", v), (vo_cyc.size() > 0) ? vo_cyc[0] : -1, vt[v].exp_first_vo);
         check($sformatf("vec%0d.done_cyc", v), (done_cyc.size() > 0) ? done_cyc[0] : -1, vt[v].exp_done);
      end

      // Backpressure: avail_in low through cycle 20.
      run_job(16'h0080, 8, 1, 2, 300);
      cnt_a = 0; cnt_b = 0;
      foreach (rd_cyc[i]) if (rd_cyc[i] <= 20) cnt_a++;
      foreach (vo_cyc[i]) if (vo_cyc[i] <= 20) cnt_b++;
      check("bp.reads_while_blocked", cnt_a, 4);
      check("bp.valid_while_blocked", cnt_b, 0);
      check_job("bp", 16'h0080, 8, 1);

      // Abort: reconfigure at cycle 3 of a 10-read job.
      clear_log();
      start_job(16'h0100, 10, 1, 0);
      step();
      step();
      bus.configure = 1'b1; bus.base_address = 16'h0200;
      step();
      bus.configure = 1'b0;
      while (cyc < 200 && !(done_cyc.size() > 0 && cyc > done_cyc[0] + 2)) step();
      begin
         logic [7:0]  post_d[$];
         int          post_c[$];
         logic [15:0] post_a[$];
         foreach (vo_cyc[i]) if (vo_cyc[i] > 3) begin post_d.push_back(vo_data[i]); post_c.push_back(vo_cyc[i]); end
         foreach (rd_cyc[i]) if (rd_cyc[i] > 3) post_a.push_back(rd_addr[i]);
         check("abort.outs", post_d.size(), 10);
         check("abort.reads", post_a.size(), 10);
         check("abort.first_vo_cyc", (post_c.size() > 0) ? post_c[0] : -1, 6);
         for (int k = 0; k < 10 && k < post_d.size(); k++)
            check("abort.data", post_d[k], mem(16'h0200 + 16'(k)));
         for (int k = 0; k < 10 && k < post_a.size(); k++)
            check("abort.addr", post_a[k], 16'h0200 + 16'(k));
         check("abort.done_cnt", done_cyc.size(), 1);
      end

      // Reset mid-job drops everything; the block stays quiet afterwards.
      clear_log();
      start_job(16'h0300, 10, 1, 0);
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) step();
      cnt_a = 0; cnt_b = 0;
      foreach (rd_cyc[i]) if (rd_cyc[i] >= 5) cnt_a++;
      foreach (vo_cyc[i]) if (vo_cyc[i] >= 5) cnt_b++;
      check("midrst.reads", cnt_a, 0);
      check("midrst.outs", cnt_b, 0);
      check("midrst.done_cnt", done_cyc.size(), 0);

      // Randomized jobs with random backpressure.
      for (int r = 0; r < 8; r++) begin
         logic [15:0] b;
         int nr, ni;
         b  = 16'($urandom);
         nr = $urandom_range(1, 6);
         ni = $urandom_range(1, 3);
         run_job(b, nr, ni, 1, 400);
         check_job($sformatf("rnd%0d", r), b, nr, ni);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
